// File: rtl/zbt_port_arbiter.sv
// zbt_port_arbiter: shares one ZBT SRAM port between a priority requester (A) and a starvation-protected requester (B)
// Address/control are registered at accept, write data follows two cycles later, read tags ride the fixed read latency.
module zbt_port_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 36,
    parameter int READ_LAT   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_grant,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_grant,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we_b,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_din
);
    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] WMAX = WW'(STARVE_MAX);

    logic [WW-1:0]     b_wait;
    logic              force_b, sel_b, acc, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, wd0, wd1;
    logic              wv0, wv1;
    logic [READ_LAT:0] tv, to;

    always_comb begin
        force_b = b_req && b_wait == WMAX;
        a_grant = !reset && a_req && !force_b;
        b_grant = !reset && b_req && (force_b || !a_req);
        sel_b   = b_req && b_grant;
        acc     = (a_req && a_grant) || sel_b;
        we      = sel_b ? b_we : a_we;
        addr    = sel_b ? b_addr : a_addr;
        wdata   = sel_b ? b_wdata : a_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b_wait   <= '0;
            ram_addr <= '0;
            ram_we_b <= 1'b1;
            ram_dout <= '0;
            ram_oe   <= 1'b0;
            wv0      <= 1'b0;
            wv1      <= 1'b0;
            wd0      <= '0;
            wd1      <= '0;
            tv       <= '0;
            to       <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            // b is always granted once b_wait reaches WMAX, so the increment never overflows
            b_wait   <= (b_req && !b_grant) ? b_wait + 1'b1 : '0;
            ram_addr <= acc ? addr : ram_addr;
            ram_we_b <= !(acc && we);
            wv0      <= acc && we;
            wd0      <= (acc && we) ? wdata : wd0;
            wv1      <= wv0;
            wd1      <= wd0;
            ram_oe   <= wv1;
            ram_dout <= wv1 ? wd1 : ram_dout;
            tv       <= {tv[READ_LAT-1:0], acc && !we};
            to       <= {to[READ_LAT-1:0], sel_b};
            a_rvalid <= tv[READ_LAT] && !to[READ_LAT];
            b_rvalid <= tv[READ_LAT] && to[READ_LAT];
            a_rdata  <= (tv[READ_LAT] && !to[READ_LAT]) ? ram_din : a_rdata;
            b_rdata  <= (tv[READ_LAT] && to[READ_LAT]) ? ram_din : b_rdata;
        end
    end
endmodule

// File: tb/tb_zbt_port_arbiter.sv
// tb_zbt_port_arbiter: directed stimulus with a scoreboard of address, write-bus and read-return expectations
// A small ZBT model (2-cycle read latency, write data 2 cycles after address) sits on the RAM pins.
module tb_zbt_port_arbiter;
    logic        clk = 0, reset = 1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [18:0] a_addr = 0, b_addr = 0;
    logic [35:0] a_wdata = 0, b_wdata = 0;
    logic        a_grant, a_rvalid, b_grant, b_rvalid, ram_we_b, ram_oe;
    logic [35:0] a_rdata, b_rdata, ram_dout, ram_din;
    logic [18:0] ram_addr;

    zbt_port_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_grant(a_grant), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_grant(b_grant), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_we_b(ram_we_b), .ram_dout(ram_dout),
        .ram_oe(ram_oe), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] init_val(input logic [18:0] a);
        return {17'h1A5A5, a};
    endfunction

    // SRAM model
    logic [18:0] p0, p1;
    logic [35:0] mem [0:2047];
    bit          mem_ok [0:2047];
    assign ram_din = mem_ok[p1[10:0]] ? mem[p1[10:0]] : init_val(p1);
    always @(posedge clk) begin
        p0 <= ram_addr;
        p1 <= p0;
        if (ram_oe) begin
            mem[p1[10:0]]    <= ram_dout;
            mem_ok[p1[10:0]] <= 1'b1;
        end
    end

    typedef struct { logic [18:0] addr; logic we; int due; } a_t;
    typedef struct { logic [35:0] data; int due; } w_t;
    typedef struct { logic own_b; logic [35:0] data; int due; } r_t;
    a_t aq[$];
    w_t wq[$];
    r_t rq[$];
    logic [35:0] shadow [0:2047];
    bit          shadow_ok [0:2047];
    int          cyc = 0, vecs = 0, errs = 0;
    bit          mon_on = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // issue side: record expectations at every accepting edge
    always @(posedge clk) begin
        logic        ob, w;
        logic [18:0] ad;
        logic [35:0] wd, rd;
        if (reset) begin
            aq.delete(); wq.delete(); rq.delete();
            mon_on = 1;
        end else if ((a_req && a_grant) || (b_req && b_grant)) begin
            ob = b_req && b_grant;
            ad = ob ? b_addr : a_addr;
            w  = ob ? b_we : a_we;
            wd = ob ? b_wdata : a_wdata;
            aq.push_back('{ad, w, cyc + 1});
            if (w) begin
                wq.push_back('{wd, cyc + 3});
                shadow[ad[10:0]] = wd;
                shadow_ok[ad[10:0]] = 1;
            end else begin
                rd = shadow_ok[ad[10:0]] ? shadow[ad[10:0]] : init_val(ad);
                rq.push_back('{ob, rd, cyc + 4});
            end
        end
    end

    // monitor: compare pins against the queue heads each cycle
    always @(negedge clk) begin
        a_t ea;
        w_t ew;
        r_t er;
        if (mon_on) begin
            if (aq.size() != 0 && aq[0].due == cyc) begin
                ea = aq.pop_front();
                chk("ram_addr", 64'(ram_addr), 64'(ea.addr));
                chk("ram_we_b", 64'(ram_we_b), 64'(!ea.we));
            end else chk("idle_we_b", 64'(ram_we_b), 64'd1);
            if (wq.size() != 0 && wq[0].due == cyc) begin
                ew = wq.pop_front();
                chk("wr_oe", 64'(ram_oe), 64'd1);
                chk("wr_dout", 64'(ram_dout), 64'(ew.data));
            end else chk("idle_oe", 64'(ram_oe), 64'd0);
            if (rq.size() != 0 && rq[0].due == cyc) begin
                er = rq.pop_front();
                chk("rvalid_owner", 64'({a_rvalid, b_rvalid}), er.own_b ? 64'd1 : 64'd2);
                chk("rdata", 64'(er.own_b ? b_rdata : a_rdata), 64'(er.data));
            end else chk("idle_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
        end
    end

    task automatic step(input logic rs, input logic ar, input logic aw, input logic [18:0] aa,
                        input logic [35:0] ad, input logic br, input logic bw, input logic [18:0] ba,
                        input logic [35:0] bd, input logic [1:0] eg, input string nm);
        @(negedge clk);
        reset = rs; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1 chk(nm, 64'({a_grant, b_grant}), 64'(eg));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, "idle_grant");
    endtask

    initial begin
        int na, nb;
        step(1, 1, 1, 19'h10, 36'h1, 1, 0, 19'h20, 36'h2, 2'b00, "rst_grant");
        step(1, 1, 0, 19'h10, 36'h1, 1, 1, 19'h20, 36'h2, 2'b00, "rst_grant");
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_dout", 64'(ram_dout), 64'd0);
        chk("rst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
        // A write then read back
        step(0, 1, 1, 19'h10, 36'h123456789, 0, 0, 0, 0, 2'b10, "a_wr_grant");
        step(0, 1, 0, 19'h10, 36'h0, 0, 0, 0, 0, 2'b10, "a_rd_grant");
        idle(4);
        // priority, then B once A drops
        step(0, 1, 0, 19'h100, 0, 1, 0, 19'h200, 0, 2'b10, "prio_a");
        step(0, 0, 0, 0, 0, 1, 0, 19'h200, 0, 2'b01, "prio_b");
        idle(5);
        // starvation override under continuous A
        na = 0; nb = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 19'(32'h300 + na), 0, 1, 0, 19'(32'h400 + nb), 0,
                 (i == 4 || i == 9) ? 2'b01 : 2'b10, "starve_grant");
            if (i == 4 || i == 9) nb++; else na++;
        end
        step(0, 1, 0, 19'h310, 0, 1, 0, 19'h410, 0, 2'b10, "wait_cleared");
        idle(5);
        // back-to-back W/R alternating A/B
        for (int i = 0; i < 8; i++)
            if (i % 2 == 0) step(0, 1, 1, 19'(32'h500 + i / 2), 36'hC0DE0000 + 36'(i), 0, 0, 0, 0, 2'b10, "b2b_a");
            else            step(0, 0, 0, 0, 0, 1, 0, 19'(32'h500 + i / 2), 0, 2'b01, "b2b_b");
        idle(6);
        // reset with a write and a read in flight
        step(0, 1, 1, 19'h20, 36'hDEAD, 0, 0, 0, 0, 2'b10, "mid_wr");
        step(0, 1, 0, 19'h10, 0, 0, 0, 0, 0, 2'b10, "mid_rd");
        step(1, 1, 0, 19'h10, 0, 1, 0, 19'h11, 0, 2'b00, "mid_rst");
        idle(6);
        chk("drain", 64'(aq.size() + wq.size() + rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
